// File: rtl/memoria_coordenadas_if.sv
// rtl/memoria_coordenadas_if.sv - controller<->RAM coordinate bus; error_paridad only with PARIDAD_MEMORIA_EN
interface memoria_coordenadas_if #(
  parameter int bits_coordenada  = 12,
  parameter int direccionamiento = 4
);
  logic                        solicitud;
  logic                        leer_escribir_memoria;
  logic                        reset_memoria;
  logic [direccionamiento:0]   direccion_memoria;
  logic [bits_coordenada-1:0]  dato_escribir_memoria;
  logic [bits_coordenada-1:0]  dato_leer_memoria;
  logic                        dato_siguiente;
  logic                        corte_terminado;
  logic [direccionamiento+1:0] cantidad_datos;
  logic                        memoria_llena;
  logic                        ocupado;
`ifdef PARIDAD_MEMORIA_EN
  logic                        error_paridad;
`endif

  modport master (
`ifdef PARIDAD_MEMORIA_EN
    input  error_paridad,
`endif
    output solicitud, leer_escribir_memoria, reset_memoria,
    output direccion_memoria, dato_escribir_memoria,
    input  dato_leer_memoria, dato_siguiente, corte_terminado,
    input  cantidad_datos, memoria_llena, ocupado
  );

  modport slave (
`ifdef PARIDAD_MEMORIA_EN
    output error_paridad,
`endif
    input  solicitud, leer_escribir_memoria, reset_memoria,
    input  direccion_memoria, dato_escribir_memoria,
    output dato_leer_memoria, dato_siguiente, corte_terminado,
    output cantidad_datos, memoria_llena, ocupado
  );
endinterface

// File: rtl/memoria_coordenadas.sv
// rtl/memoria_coordenadas.sv - coordinate RAM responder with clear sweep and end-of-path flag
// Optional per-word even parity with error_paridad output when PARIDAD_MEMORIA_EN is defined.
module memoria_coordenadas #(
  parameter int bits_coordenada  = 12,
  parameter int direccionamiento = 4
) (
  input logic                  clock,
  input logic                  reset,
  memoria_coordenadas_if.slave bus
);
  localparam int AW    = direccionamiento + 1;
  localparam int CW    = direccionamiento + 2;
  localparam int DEPTH = 2 ** AW;
`ifdef PARIDAD_MEMORIA_EN
  localparam int RW = bits_coordenada + 1;
`else
  localparam int RW = bits_coordenada;
`endif

  typedef enum logic [1:0] {LIBRE, LEER, ENTREGAR, BORRAR} estado_t;

  estado_t                    estado, estado_sig;
  logic [RW-1:0]              ram [DEPTH];
  logic [AW-1:0]              dir_q;
  logic [AW-1:0]              barrido;
  logic [CW-1:0]              cantidad;
  logic [bits_coordenada-1:0] dato_q;
  logic                       corte_q;
`ifdef PARIDAD_MEMORIA_EN
  logic                       err_q;
`endif

  logic          aceptar, escribir_ext, leer_ext, acierto;
  logic          ram_we;
  logic [AW-1:0] ram_dir;
  logic [RW-1:0] ram_wd, ram_rd;

  assign aceptar      = (estado == LIBRE) && bus.solicitud && !bus.reset_memoria;
  assign escribir_ext = aceptar && bus.leer_escribir_memoria;
  assign leer_ext     = aceptar && !bus.leer_escribir_memoria;
  assign acierto      = {1'b0, dir_q} < cantidad;

  // Single port: the sweep owns it in BORRAR, the latched read address in LEER.
  assign ram_we  = escribir_ext || ((estado == BORRAR) && !bus.reset_memoria);
  assign ram_dir = (estado == BORRAR) ? barrido :
                   (estado == LEER)   ? dir_q   : bus.direccion_memoria;
`ifdef PARIDAD_MEMORIA_EN
  assign ram_wd  = (estado == BORRAR) ? '0 :
                   {^bus.dato_escribir_memoria, bus.dato_escribir_memoria};
`else
  assign ram_wd  = (estado == BORRAR) ? '0 : bus.dato_escribir_memoria;
`endif
  assign ram_rd  = ram[ram_dir];

  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_dir] <= ram_wd;
  end

  always_ff @(posedge clock) begin
    if (reset) estado <= LIBRE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    if (bus.reset_memoria) begin
      estado_sig = BORRAR;
    end else begin
      case (estado)
        LIBRE:    if (leer_ext) estado_sig = LEER;
        LEER:     estado_sig = ENTREGAR;
        ENTREGAR: estado_sig = LIBRE;
        BORRAR:   if (barrido == '1) estado_sig = LIBRE;
        default:  estado_sig = LIBRE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q    <= '0;
      barrido  <= '0;
      cantidad <= '0;
      dato_q   <= '0;
      corte_q  <= 1'b0;
`ifdef PARIDAD_MEMORIA_EN
      err_q    <= 1'b0;
`endif
    end else if (bus.reset_memoria) begin
      barrido  <= '0;
      cantidad <= '0;
      dato_q   <= '0;
      corte_q  <= 1'b0;
`ifdef PARIDAD_MEMORIA_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (estado)
        LIBRE: begin
          if (aceptar) begin
            corte_q <= 1'b0;
            dir_q   <= bus.direccion_memoria;
            // Count is the highest written address plus one, never shrinks.
            if (escribir_ext && ({1'b0, bus.direccion_memoria} >= cantidad))
              cantidad <= {1'b0, bus.direccion_memoria} + 1'b1;
          end
        end
        LEER: begin
          dato_q  <= acierto ? ram_rd[bits_coordenada-1:0] : '0;
          corte_q <= !acierto;
`ifdef PARIDAD_MEMORIA_EN
          err_q   <= acierto && (^ram_rd);
`endif
        end
        BORRAR:  barrido <= barrido + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.dato_leer_memoria = dato_q;
  assign bus.dato_siguiente    = (estado == ENTREGAR);
  assign bus.corte_terminado   = corte_q;
  assign bus.cantidad_datos    = cantidad;
  assign bus.memoria_llena     = (cantidad == CW'(DEPTH));
  assign bus.ocupado           = (estado != LIBRE);
`ifdef PARIDAD_MEMORIA_EN
  assign bus.error_paridad     = err_q && (estado == ENTREGAR);
`endif
endmodule

// File: tb/tb_memoria_coordenadas.sv
// tb/tb_memoria_coordenadas.sv - directed plus random bench for memoria_coordenadas against an array model
module tb_memoria_coordenadas;
  localparam int BC    = 12;
  localparam int DA    = 4;
  localparam int DEPTH = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  memoria_coordenadas_if #(.bits_coordenada(BC), .direccionamiento(DA)) bus ();
  memoria_coordenadas #(.bits_coordenada(BC), .direccionamiento(DA)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [BC-1:0] modelo [DEPTH];
  int            cuenta;
  logic          corte_modelo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic escribir(input int a, input int d);
    bus.solicitud             = 1'b1;
    bus.leer_escribir_memoria = 1'b1;
    bus.direccion_memoria     = 5'(a);
    bus.dato_escribir_memoria = 12'(d);
    tick();
    bus.solicitud = 1'b0;
    modelo[a] = 12'(d);
    if (a + 1 > cuenta) cuenta = a + 1;
    corte_modelo = 1'b0;
    check("wr_ocupado", 32'(bus.ocupado), 32'(0));
    check("wr_cantidad", 32'(bus.cantidad_datos), 32'(cuenta));
    check("wr_llena", 32'(bus.memoria_llena), 32'(cuenta == DEPTH));
    check("wr_corte", 32'(bus.corte_terminado), 32'(0));
  endtask

  task automatic leer(input int a, input logic exp_err = 1'b0);
    logic [BC-1:0] esperado;
    esperado     = (a < cuenta) ? modelo[a] : '0;
    corte_modelo = (a >= cuenta);
    bus.solicitud             = 1'b1;
    bus.leer_escribir_memoria = 1'b0;
    bus.direccion_memoria     = 5'(a);
    tick();
    bus.solicitud = 1'b0;
    check("rd_ocupado", 32'(bus.ocupado), 32'(1));
    check("rd_pulso_t1", 32'(bus.dato_siguiente), 32'(0));
    tick();
    check("rd_pulso_t2", 32'(bus.dato_siguiente), 32'(1));
    check("rd_dato", 32'(bus.dato_leer_memoria), 32'(esperado));
    check("rd_corte", 32'(bus.corte_terminado), 32'(corte_modelo));
`ifdef PARIDAD_MEMORIA_EN
    check("rd_paridad", 32'(bus.error_paridad), 32'(exp_err));
`else
    if (exp_err) check("rd_paridad_sin_soporte", 32'(exp_err), 32'(0));
`endif
    tick();
    check("rd_pulso_t3", 32'(bus.dato_siguiente), 32'(0));
    check("rd_libre", 32'(bus.ocupado), 32'(0));
    check("rd_dato_retenido", 32'(bus.dato_leer_memoria), 32'(esperado));
    check("rd_corte_retenido", 32'(bus.corte_terminado), 32'(corte_modelo));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic vio_pulso;

    bus.solicitud             = 1'b0;
    bus.leer_escribir_memoria = 1'b0;
    bus.reset_memoria         = 1'b0;
    bus.direccion_memoria     = '0;
    bus.dato_escribir_memoria = '0;
    for (int i = 0; i < DEPTH; i++) modelo[i] = '0;
    cuenta       = 0;
    corte_modelo = 1'b0;

    reset = 1'b1;
    tick(); tick(); tick();
    check("rst_ocupado", 32'(bus.ocupado), 32'(0));
    check("rst_cantidad", 32'(bus.cantidad_datos), 32'(0));
    check("rst_llena", 32'(bus.memoria_llena), 32'(0));
    check("rst_pulso", 32'(bus.dato_siguiente), 32'(0));
    check("rst_corte", 32'(bus.corte_terminado), 32'(0));
    check("rst_dato", 32'(bus.dato_leer_memoria), 32'(0));
    reset = 1'b0;
    tick();

    // Recording three points, then one hit and one end-of-path read.
    escribir(0, 'h041);
    escribir(1, 'h082);
    escribir(2, 'h0C3);
    check("t1_cantidad", 32'(bus.cantidad_datos), 32'(3));
    leer(1);
    check("t2_dato", 32'(bus.dato_leer_memoria), 32'h082);
    leer(3);
    tick(); tick(); tick();
    check("t3_corte_mantenido", 32'(bus.corte_terminado), 32'(1));
    check("t3_dato_cero", 32'(bus.dato_leer_memoria), 32'(0));
    escribir(3, 'h104);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) escribir(int'($urandom_range(0, 20)), int'($urandom_range(0, 4095)));
      else                           leer(int'($urandom_range(0, 31)));
    end

    for (int a = 0; a < DEPTH; a++) escribir(a, int'($urandom_range(0, 4095)));
    check("t4_llena", 32'(bus.memoria_llena), 32'(1));
    escribir(5, 'h555);
    check("t4_reescritura", 32'(bus.cantidad_datos), 32'(32));
    leer(31);
    leer(5);

    // Clear issued while a read is in LEER: the read must be abandoned.
    bus.solicitud             = 1'b1;
    bus.leer_escribir_memoria = 1'b0;
    bus.direccion_memoria     = 5'(2);
    tick();
    bus.solicitud     = 1'b0;
    bus.reset_memoria = 1'b1;
    tick();
    bus.reset_memoria = 1'b0;
    vio_pulso = bus.dato_siguiente;
    check("t5_cantidad_cero", 32'(bus.cantidad_datos), 32'(0));
    check("t5_dato_cero", 32'(bus.dato_leer_memoria), 32'(0));
    n = 0;
    while (bus.ocupado === 1'b1 && n < 200) begin
      n++;
      if (n == 5) begin
        bus.solicitud             = 1'b1;
        bus.leer_escribir_memoria = 1'b1;
        bus.direccion_memoria     = 5'(7);
        bus.dato_escribir_memoria = 12'hFFF;
      end
      tick();
      bus.solicitud = 1'b0;
      if (bus.dato_siguiente === 1'b1) vio_pulso = 1'b1;
    end
    check("t5_duracion_barrido", 32'(n), 32'(32));
    check("t5_sin_pulso", 32'(vio_pulso), 32'(0));
    for (int i = 0; i < DEPTH; i++) modelo[i] = '0;
    cuenta       = 0;
    corte_modelo = 1'b0;
    check("t5_cantidad", 32'(bus.cantidad_datos), 32'(0));
    check("t5_llena", 32'(bus.memoria_llena), 32'(0));
    check("t5_corte", 32'(bus.corte_terminado), 32'(0));

    // Unmask the whole RAM so every swept word becomes observable.
    escribir(31, 'hABC);
    for (int a = 0; a < DEPTH; a++) leer(a);

    bus.reset_memoria = 1'b1;
    tick();
    bus.reset_memoria = 1'b0;
    n = 0;
    while (bus.ocupado === 1'b1 && n < 200) begin
      n++;
      if (n == 10) bus.reset_memoria = 1'b1;
      tick();
      bus.reset_memoria = 1'b0;
    end
    check("t5_barrido_reiniciado", 32'(n), 32'(42));
    for (int i = 0; i < DEPTH; i++) modelo[i] = '0;
    cuenta = 0;
    check("t5_cantidad_reinicio", 32'(bus.cantidad_datos), 32'(0));

`ifdef PARIDAD_MEMORIA_EN
    escribir(0, 'h041);
    leer(0, 1'b0);
    dut.ram[0] = dut.ram[0] ^ 13'h001;
    modelo[0] = modelo[0] ^ 12'h001;
    leer(0, 1'b1);
    escribir(1, 'h082);
    leer(1, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
